spectrum_frame_tx: RTL and testbench

Frames a snapshot of per-bin transform magnitudes into a byte stream for the UART transmitter (serial_TX-style new_data/busy/block handshake). It replaces the fixed "send result[23:16] of one bin" path with a parametrised framer covering N bins, selectable byte count per bin, a sync header and drop accounting. It sits between the transform engine and the serial transmitter.

---
 rtl/spectrum_frame_tx.sv | 167 ++++++++++++++++
 tb/tb_spectrum_frame_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_frame_tx.sv
// Frames a frozen snapshot of NUM_BINS transform results into a byte stream for a serial_TX-style UART.
// Optional trailing mod-256 payload checksum byte is built when FRAME_CHECKSUM_EN is defined.
module spectrum_frame_tx #(
  parameter int unsigned NUM_BINS      = 4,
  parameter int unsigned RESULT_WIDTH  = 24,
  parameter int unsigned BYTES_PER_BIN = 1,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_BINS*RESULT_WIDTH-1:0] results,
  input  logic                             results_valid,
  output logic [7:0]                       tx_data,
  output logic                             tx_new_data,
  input  logic                             tx_busy,
  input  logic                             tx_block,
  output logic                             frame_busy,
  output logic [7:0]                       frames_dropped
);

  localparam int unsigned BUS_W       = NUM_BINS * RESULT_WIDTH;
  localparam int unsigned PAYLOAD_LEN = NUM_BINS * BYTES_PER_BIN;
`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN   = PAYLOAD_LEN + 2;
`else
  localparam int unsigned FRAME_LEN   = PAYLOAD_LEN + 1;
`endif
  localparam int unsigned IDX_W       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned PIDX_W      = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_FREE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BUS_W-1:0]   shadow_q, shadow_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_new_data_q, tx_new_data_d;
  logic               frame_busy_q, frame_busy_d;
  logic [7:0]         dropped_q, dropped_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic [7:0]         payload [PAYLOAD_LEN];
  logic [7:0]         cur_byte_c;
  logic               in_payload_c;
  logic               last_byte_c;
  logic [PIDX_W-1:0]  pidx_c;

  // Payload byte p = bin p/BYTES_PER_BIN, byte p%BYTES_PER_BIN counted from the MSB end
  for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
    for (genvar j = 0; j < BYTES_PER_BIN; j++) begin : g_byte
      assign payload[k*BYTES_PER_BIN + j] =
        shadow_q[k*RESULT_WIDTH + RESULT_WIDTH - 1 - 8*j -: 8];
    end
  end

  // Byte selected by the frame index: header, payload, then optional checksum
  always_comb begin
    in_payload_c = (idx_q != '0) && (idx_q <= IDX_W'(PAYLOAD_LEN));
    last_byte_c  = (idx_q == IDX_W'(FRAME_LEN - 1));
    pidx_c       = PIDX_W'(idx_q - IDX_W'(1));
    cur_byte_c   = SYNC_BYTE;
    if (in_payload_c) begin
      cur_byte_c = payload[pidx_c];
    end
`ifdef FRAME_CHECKSUM_EN
    if (last_byte_c) begin
      cur_byte_c = csum_q;
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    tx_data_d     = tx_data_q;
    tx_new_data_d = 1'b0;
    frame_busy_d  = frame_busy_q;
    dropped_d     = dropped_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    // Any capture request outside IDLE is lost; the counter sticks at its maximum
    if (results_valid && (state_q != IDLE) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (results_valid) begin
          shadow_d     = results;
          idx_d        = '0;
          frame_busy_d = 1'b1;
          state_d      = SEND;
`ifdef FRAME_CHECKSUM_EN
          csum_d       = 8'd0;
`endif
        end
      end
      SEND: begin
        if (!tx_busy && !tx_block) begin
          tx_data_d     = cur_byte_c;
          tx_new_data_d = 1'b1;
          state_d       = WAIT_ACK;
`ifdef FRAME_CHECKSUM_EN
          if (in_payload_c) begin
            csum_d = csum_q + cur_byte_c;
          end
`endif
        end
      end
      // Transmitter raises busy one cycle after the strobe; skip that cycle
      WAIT_ACK: begin
        state_d = WAIT_FREE;
      end
      WAIT_FREE: begin
        if (!tx_busy) begin
          if (last_byte_c) begin
            frame_busy_d = 1'b0;
            state_d      = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      shadow_q      <= '0;
      tx_data_q     <= 8'd0;
      tx_new_data_q <= 1'b0;
      frame_busy_q  <= 1'b0;
      dropped_q     <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
      csum_q        <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      tx_data_q     <= tx_data_d;
      tx_new_data_q <= tx_new_data_d;
      frame_busy_q  <= frame_busy_d;
      dropped_q     <= dropped_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_new_data    = tx_new_data_q;
  assign frame_busy     = frame_busy_q;
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_spectrum_frame_tx.sv
// Scoreboard bench for spectrum_frame_tx: random frames, drops, flow-control holds, mid-frame reset,
// plus a second instance with two bytes per bin. Honours FRAME_CHECKSUM_EN like the design.
module tb_spectrum_frame_tx;

  localparam int unsigned NB    = 4;
  localparam int unsigned RW    = 24;
  localparam int unsigned BPB   = 1;
  localparam int unsigned BUS   = NB * RW;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic           clk = 1'b0;
  logic           rst;
  logic [BUS-1:0] results;
  logic           results_valid;
  logic [7:0]     tx_data;
  logic           tx_new_data;
  logic           tx_busy;
  logic           tx_block;
  logic           frame_busy;
  logic [7:0]     frames_dropped;

  logic [23:0]    results2;
  logic           results_valid2;
  logic [7:0]     tx_data2;
  logic           tx_new_data2;
  logic           tx_busy2;
  logic           tx_block2;
  logic           frame_busy2;
  logic [7:0]     frames_dropped2;

  always #5 clk = ~clk;

  spectrum_frame_tx #(.NUM_BINS(NB), .RESULT_WIDTH(RW), .BYTES_PER_BIN(BPB), .SYNC_BYTE(SYNC)) u_dut (
    .clk(clk), .rst(rst), .results(results), .results_valid(results_valid),
    .tx_data(tx_data), .tx_new_data(tx_new_data), .tx_busy(tx_busy), .tx_block(tx_block),
    .frame_busy(frame_busy), .frames_dropped(frames_dropped)
  );

  spectrum_frame_tx #(.NUM_BINS(1), .RESULT_WIDTH(24), .BYTES_PER_BIN(2), .SYNC_BYTE(SYNC)) u_dut2 (
    .clk(clk), .rst(rst), .results(results2), .results_valid(results_valid2),
    .tx_data(tx_data2), .tx_new_data(tx_new_data2), .tx_busy(tx_busy2), .tx_block(tx_block2),
    .frame_busy(frame_busy2), .frames_dropped(frames_dropped2)
  );

  // serial_TX-like responders: busy rises the cycle after new_data and lasts tx_lat cycles
  int tx_lat = 2;
  int busy_cnt = 0;
  int busy_cnt2 = 0;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (tx_new_data) busy_cnt <= tx_lat;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (rst) busy_cnt2 <= 0;
    else if (tx_new_data2) busy_cnt2 <= 2;
    else if (busy_cnt2 != 0) busy_cnt2 <= busy_cnt2 - 1;
  end
  assign tx_busy  = (busy_cnt != 0);
  assign tx_busy2 = (busy_cnt2 != 0);

  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_drops = 0;
  int strobe_cnt = 0;
  longint cyc = 0;
  longint last_strobe = -100;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe pops the scoreboard and is checked for order, framing and spacing
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && tx_new_data) begin
      strobe_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_byte: got %02h, no byte expected (cycle %0d)", tx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_bad++;
          $display("FAIL byte_order: got %02h, expected %02h (cycle %0d)", tx_data, e, cyc);
        end
      end
      n_cmp++;
      if (frame_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_during_strobe: frame_busy=%b, expected 1", frame_busy);
      end
      n_cmp++;
      if (cyc - last_strobe < 3) begin
        n_bad++;
        $display("FAIL strobe_spacing: %0d cycles, expected >= 3", cyc - last_strobe);
      end
      last_strobe = cyc;
    end
    if (!rst && tx_new_data2) begin
      n_cmp++;
      if (exp2_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_byte2: got %02h, no byte expected", tx_data2);
      end else begin
        e = exp2_q.pop_front();
        if (tx_data2 !== e) begin
          n_bad++;
          $display("FAIL byte_order2: got %02h, expected %02h", tx_data2, e);
        end
      end
    end
  end

  // Reference framing: header, each bin's top bytes MSB first, optional checksum of payload
  task automatic push_frame(input logic [BUS-1:0] r);
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'd0;
    exp_q.push_back(SYNC);
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < BPB; j++) begin
        b = 8'(r >> (k * RW + RW - 8 - 8 * j));
        exp_q.push_back(b);
        sum = sum + b;
      end
    end
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  // A pulse is captured only when no frame is in flight, otherwise it is counted as dropped
  task automatic drive_cycle(input logic v, input logic [BUS-1:0] r);
    @(negedge clk);
    results       = r;
    results_valid = v;
    if (v) begin
      if (frame_busy) begin
        if (exp_drops < 255) exp_drops++;
      end else begin
        push_frame(r);
      end
    end
  endtask

  function automatic logic [BUS-1:0] rand_bus();
    logic [BUS-1:0] r;
    for (int k = 0; k < NB; k++) r[k*RW +: RW] = RW'($urandom);
    return r;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((frame_busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++;
    if (frame_busy || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: frame_busy=%b with %0d bytes outstanding, expected idle and empty",
               name, frame_busy, exp_q.size());
    end
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n;
    n = 0;
    while (strobe_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++;
    if (strobe_cnt < target) begin
      n_bad++;
      $display("FAIL strobe_timeout: got %0d strobes, expected %0d", strobe_cnt, target);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    logic [BUS-1:0] r;
    int base;
    rst = 1'b1; results = '0; results_valid = 1'b0; tx_block = 1'b0;
    results2 = '0; results_valid2 = 1'b0; tx_block2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("reset_tx_new_data", int'(tx_new_data), 0);
    check_val("reset_tx_data", int'(tx_data), 0);
    check_val("reset_frame_busy", int'(frame_busy), 0);
    check_val("reset_dropped", int'(frames_dropped), 0);

    // Idle with responder active: nothing may be sent
    repeat (20) drive_cycle(1'b0, '0);
    check_val("idle_strobes", strobe_cnt, 0);
    check_val("idle_dropped", int'(frames_dropped), 0);

    // Directed frame: A5,0F,01,02,03 (+15 with checksum)
    r = {24'h030000, 24'h020000, 24'h010000, 24'h0F0000};
    drive_cycle(1'b1, r);
    drive_cycle(1'b0, rand_bus());
    wait_done("directed_frame", 200);
`ifdef FRAME_CHECKSUM_EN
    check_val("directed_strobes", strobe_cnt, 6);
`else
    check_val("directed_strobes", strobe_cnt, 5);
`endif

    // Random traffic: pulses, flow-control holds, varying transmitter latency
    for (int i = 0; i < 800; i++) begin
      drive_cycle(($urandom_range(0, 4) == 0), rand_bus());
      tx_block = ($urandom_range(0, 3) == 0);
      tx_lat   = $urandom_range(1, 4);
    end
    drive_cycle(1'b0, '0);
    tx_block = 1'b0;
    wait_done("random_frames", 400);
    check_val("random_dropped", int'(frames_dropped), exp_drops);

    // Mid-frame hold with a flood of pulses: no strobes while held, drops saturate
    tx_lat = 2;
    base = strobe_cnt;
    drive_cycle(1'b1, rand_bus());
    drive_cycle(1'b0, rand_bus());
    wait_strobes(base + 2, 100);
    tx_block = 1'b1;
    base = strobe_cnt;
    for (int i = 0; i < 320; i++) drive_cycle(1'b1, rand_bus());
    drive_cycle(1'b0, rand_bus());
    check_val("strobes_while_blocked", strobe_cnt - base, 0);
    check_val("dropped_saturated", int'(frames_dropped), exp_drops);
    check_val("dropped_is_255", exp_drops, 255);
    tx_block = 1'b0;
    wait_done("frame_after_block", 200);
    check_val("dropped_still_255", int'(frames_dropped), 255);

    // Reset mid-frame aborts everything; next frame restarts from the header
    base = strobe_cnt;
    drive_cycle(1'b1, rand_bus());
    drive_cycle(1'b0, rand_bus());
    wait_strobes(base + 2, 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check_val("midrst_tx_new_data", int'(tx_new_data), 0);
    check_val("midrst_frame_busy", int'(frame_busy), 0);
    check_val("midrst_dropped", int'(frames_dropped), 0);
    exp_q.delete();
    exp_drops = 0;
    rst = 1'b0;
    drive_cycle(1'b1, {24'h030000, 24'h020000, 24'h010000, 24'h0F0000});
    drive_cycle(1'b0, '0);
    wait_done("frame_after_reset", 200);

    // Two bytes per bin: A5,AB,CD (+78 with checksum)
    @(negedge clk);
    results2 = 24'hABCD12;
    results_valid2 = 1'b1;
    exp2_q.push_back(8'hA5);
    exp2_q.push_back(8'hAB);
    exp2_q.push_back(8'hCD);
`ifdef FRAME_CHECKSUM_EN
    exp2_q.push_back(8'h78);
`endif
    @(negedge clk);
    results_valid2 = 1'b0;
    results2 = 24'h000000;
    begin
      int n;
      n = 0;
      while ((frame_busy2 || exp2_q.size() != 0) && n < 200) begin
        @(negedge clk); #1;
        n++;
      end
    end
    check_val("bpb2_outstanding", exp2_q.size(), 0);
    check_val("bpb2_frame_busy", int'(frame_busy2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
